// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and request legality check for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StMerge,
        StResp
    } lsu_state_e;

    // Size 11 is never legal; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load lanes and merges store data into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: load_data = word;
        endcase
    end

    // Word-sized stores replace the whole word, so merged is simply wdata.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed memory; sub-word stores use
// read-modify-write, illegal requests are answered with an error and never reach memory.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic        valid_q;
    logic        err_q;

    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] merged;

    // ACCESS works on the live memory word, MERGE on the copy captured during ACCESS.
    assign align_word = (state_q == StMerge) ? word_q : mem_RD;

    lsu_lane_align u_lane_align (
        .word        (align_word),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign req_ready  = rst && (state_q == StIdle);
    assign mem_A      = {addr_q[31:2], 2'b00};
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    always_comb begin
        mem_WE = 1'b0;
        mem_WD = 32'h0;
        case (state_q)
            StAccess: begin
                if (we_q && (size_q == SZ_WORD)) begin
                    mem_WE = 1'b1;
                    mem_WD = merged;
                end
            end
            StMerge: begin
                mem_WE = 1'b1;
                mem_WD = merged;
            end
            default: begin
                mem_WE = 1'b0;
                mem_WD = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        if (is_illegal(req_size, req_addr[1:0])) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                        valid_q <= 1'b1;
                        state_q <= StResp;
                    end else if (size_q == SZ_WORD) begin
                        rdata_q <= 32'h0;
                        valid_q <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        word_q  <= mem_RD;
                        state_q <= StMerge;
                    end
                end
                StMerge: begin
                    rdata_q <= 32'h0;
                    valid_q <= 1'b1;
                    state_q <= StResp;
                end
                StResp: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard, with a word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_WE       (mem_WE),
        .mem_RD       (mem_RD)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [64];
    assign mem_RD = rst ? mem[mem_A[7:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8899AABB;
        mem[12] = 32'h11223344;
        forever begin
            @(posedge clk);
            if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept;
        int          we_exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   we_cnt = 0;
    int   last_accept = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: counts write strobes and scores every response against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            we_cnt = 0;
        end else begin
            if (mem_WE) begin
                we_cnt++;
                check("mem_A_bits", {6'h0, mem_A[31:8], mem_A[1:0]}, 32'h0);
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    check("resp_latency", cyc - e.accept + 1, e.lat);
                    check("mem_we_count", we_cnt, e.we_exp);
                    we_cnt = 0;
                end
            end
        end
    end

    task automatic do_req(input vec_t v);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (req_ready) begin
                e.rdata  = v.exp_rdata;
                e.err    = v.exp_err;
                e.lat    = v.exp_err ? 1 : ((v.we && v.size != SZ_WORD) ? 3 : 2);
                e.we_exp = (v.we && !v.exp_err) ? 1 : 0;
                e.accept = cyc + 1;
                last_accept = e.accept;
                sb_q.push_back(e);
                done = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("resp_timeout", sb_q.size(), 32'h0);
            sb_q.delete();
        end
    endtask

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        int first_accept;
        req_valid = 0; req_we = 0; req_size = SZ_BYTE; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;

        vecs[0]  = mk(0, SZ_BYTE, 0, 32'h11, 32'h0,        32'hFFFFFFAA, 0);
        vecs[1]  = mk(0, SZ_BYTE, 1, 32'h11, 32'h0,        32'h000000AA, 0);
        vecs[2]  = mk(0, SZ_HALF, 0, 32'h12, 32'h0,        32'hFFFF8899, 0);
        vecs[3]  = mk(0, SZ_HALF, 1, 32'h10, 32'h0,        32'h0000AABB, 0);
        vecs[4]  = mk(1, SZ_BYTE, 0, 32'h12, 32'hFFFFFF55, 32'h0,        0);
        vecs[5]  = mk(0, SZ_WORD, 0, 32'h10, 32'h0,        32'h8855AABB, 0);
        vecs[6]  = mk(1, SZ_WORD, 0, 32'h20, 32'hDEADBEEF, 32'h0,        0);
        vecs[7]  = mk(0, SZ_WORD, 0, 32'h20, 32'h0,        32'hDEADBEEF, 0);
        vecs[8]  = mk(1, SZ_HALF, 0, 32'h22, 32'hABCD1234, 32'h0,        0);
        vecs[9]  = mk(0, SZ_WORD, 0, 32'h20, 32'h0,        32'h1234BEEF, 0);
        vecs[10] = mk(0, SZ_HALF, 0, 32'h13, 32'h0,        32'h0,        1);
        vecs[11] = mk(1, SZ_WORD, 0, 32'h22, 32'h55555555, 32'h0,        1);
        vecs[12] = mk(0, 2'b11,   0, 32'h20, 32'h0,        32'h0,        1);
        vecs[13] = mk(0, SZ_BYTE, 0, 32'h13, 32'h0,        32'hFFFFFF88, 0);
        vecs[14] = mk(1, SZ_BYTE, 0, 32'h11, 32'h00000001, 32'h0,        0);
        vecs[15] = mk(0, SZ_WORD, 0, 32'h10, 32'h0,        32'h885501BB, 0);
        vecs[16] = mk(0, SZ_HALF, 0, 32'h22, 32'h0,        32'h00001234, 0);
        vecs[17] = mk(0, SZ_BYTE, 0, 32'h20, 32'h0,        32'hFFFFFFEF, 0);
        vecs[18] = mk(0, SZ_WORD, 0, 32'h20, 32'h0,        32'h1234BEEF, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_WE}, 32'h0);
        check("rst_mem_a", mem_A, 32'h0);
        check("rst_mem_wd", mem_WD, 32'h0);
        rst = 1'b1;
        #1 check("rel_req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 19; i++) begin
            do_req(vecs[i]);
            @(negedge clk);
            req_valid = 1'b0;
            drain();
        end

        // Reset during the MERGE cycle of a byte store aborts it with no write and no response.
        @(negedge clk);
        req_we = 1; req_size = SZ_BYTE; req_unsigned = 0;
        req_addr = 32'h31; req_wdata = 32'h000000AA; req_valid = 1;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("abort_access_we", {31'h0, mem_WE}, 32'h0);
        @(negedge clk);
        #1 check("abort_merge_we", {31'h0, mem_WE}, 32'h1);
        check("abort_merge_wd", mem_WD, 32'h1122AA44);
        rst = 1'b0;
        #1 check("abort_we_drop", {31'h0, mem_WE}, 32'h0);
        check("abort_ready_low", {31'h0, req_ready}, 32'h0);
        check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        check("abort_mem_a", mem_A, 32'h0);
        repeat (2) @(negedge clk);
        check("abort_ready_hold", {31'h0, req_ready}, 32'h0);
        check("abort_no_resp2", {31'h0, resp_valid}, 32'h0);
        rst = 1'b1;
        #1 check("abort_rel_ready", {31'h0, req_ready}, 32'h1);
        check("abort_mem_intact", mem[12], 32'h11223344);
        do_req(mk(0, SZ_WORD, 0, 32'h30, 32'h0, 32'h11223344, 0));
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Back-to-back loads with req_valid held high.
        do_req(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'h885501BB, 0));
        first_accept = last_accept;
        do_req(mk(0, SZ_HALF, 1, 32'h32, 32'h0, 32'h00001122, 0));
        check("b2b_accept_gap", last_accept - first_accept, 32'd3);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
